// File: rtl/ram_fifo_ctrl.sv
// Streaming FIFO controller around a simple dual-port RAM with 1-cycle registered read.
// A 2-entry output buffer hides the read latency; one push and one pop per cycle sustained.
module ram_fifo_ctrl #(
  parameter int D_WIDTH = 16,
  parameter int A_WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [D_WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] out_data,
  output logic [A_WIDTH+1:0] count,
  output logic [A_WIDTH-1:0] address_write,
  output logic [D_WIDTH-1:0] data_write,
  output logic               write_enable,
  output logic [A_WIDTH-1:0] address_read,
  input  logic [D_WIDTH-1:0] data_read
);
  localparam int DEPTH = 2 ** A_WIDTH;
  localparam logic [A_WIDTH:0] DEPTH_C = (A_WIDTH + 1)'(DEPTH);

  logic [A_WIDTH-1:0] wr_ptr;
  logic [A_WIDTH-1:0] rd_ptr;
  logic [A_WIDTH:0]   mem_count;
  logic               inflight;
  logic [1:0]         buf_count;
  logic [D_WIDTH-1:0] buf_head;
  logic [D_WIDTH-1:0] buf_tail;
  logic               push;
  logic               pop;
  logic               issue;
  logic [1:0]         buf_after_pop;

  assign in_ready  = !rst && (mem_count < DEPTH_C);
  assign push      = in_valid && in_ready;
  assign out_valid = !rst && (buf_count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_data  = buf_head;

  // Only fetch when the word is guaranteed a buffer slot on arrival.
  assign issue = (mem_count != '0) &&
                 (({1'b0, buf_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

  assign buf_after_pop = buf_count - {1'b0, pop};

  assign count = (A_WIDTH + 2)'(mem_count) + (A_WIDTH + 2)'(inflight)
               + (A_WIDTH + 2)'(buf_count);

  assign address_write = wr_ptr;
  assign data_write    = in_data;
  assign write_enable  = push;
  assign address_read  = rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      inflight  <= 1'b0;
      buf_count <= 2'd0;
      buf_head  <= '0;
      buf_tail  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + A_WIDTH'(1);
      if (issue) rd_ptr <= rd_ptr + A_WIDTH'(1);
      inflight <= issue;

      case ({push, issue})
        2'b10:   mem_count <= mem_count + (A_WIDTH + 1)'(1);
        2'b01:   mem_count <= mem_count - (A_WIDTH + 1)'(1);
        default: mem_count <= mem_count;
      endcase

      buf_count <= buf_after_pop + {1'b0, inflight};

      // Shift on pop first; the returning RAM word lands in the first free slot after the shift.
      if (pop) buf_head <= buf_tail;
      if (inflight) begin
        if (buf_after_pop == 2'd0) buf_head <= data_read;
        else                       buf_tail <= data_read;
      end
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: behavioural RAM plus queue-based reference model.
// Directed latency/fill/stream/reset scenarios and a randomized scoreboard run.
module tb_ram_fifo_ctrl;
  localparam int DW    = 16;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW+1:0] count;
  logic [AW-1:0] address_write;
  logic [DW-1:0] data_write;
  logic          write_enable;
  logic [AW-1:0] address_read;
  logic [DW-1:0] data_read;

  logic [DW-1:0] ram [DEPTH];

  int n_vec = 0;
  int n_err = 0;

  ram_fifo_ctrl #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count),
    .address_write(address_write), .data_write(data_write), .write_enable(write_enable),
    .address_read(address_read), .data_read(data_read)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (write_enable) ram[address_write] <= data_write;
    data_read <= ram[address_read];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int cycles);
    tick();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_vec++; if (count !== '0) begin n_err++; $display("FAIL rst_count got %0d want 0", count); end
    n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL rst_out_data got %h want 0", out_data); end
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL idle_in_ready got %b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL idle_out_valid got %b want 0", out_valid); end
    n_vec++; if (count !== '0) begin n_err++; $display("FAIL idle_count got %0d want 0", count); end
    n_vec++; if (write_enable !== 1'b0) begin n_err++; $display("FAIL idle_we got %b want 0", write_enable); end
  endtask

  task automatic test_single();
    apply_reset(2);
    in_valid = 1'b1; in_data = 16'hA5A5; out_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (write_enable !== 1'b1 || address_write !== 5'd0 || data_write !== 16'hA5A5) begin
      n_err++; $display("FAIL single_write got we=%b a=%0d d=%h want 1 0 a5a5", write_enable, address_write, data_write);
    end
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_vec++; if (out_valid !== (k == 3)) begin
        n_err++; $display("FAIL single_latency edge %0d got out_valid=%b want %b", k, out_valid, k == 3);
      end
      if (k < 3) tick();
    end
    n_vec++; if (out_data !== 16'hA5A5) begin n_err++; $display("FAIL single_data got %h want a5a5", out_data); end
    n_vec++; if (count !== 7'd1) begin n_err++; $display("FAIL single_count got %0d want 1", count); end
    tick();
    @(negedge clk);
    n_vec++; if (count !== '0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL single_after_pop got count=%0d ov=%b want 0 0", count, out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_fill();
    int next_val;
    int exp_val;
    int cyc;
    apply_reset(2);
    next_val = 0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      in_data = DW'(next_val);
      @(negedge clk);
      if (next_val < DEPTH) begin
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready cyc %0d got %b want 1", c, in_ready); end
      end
      if (in_ready) next_val++;
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (count !== 7'(DEPTH + 2)) begin n_err++; $display("FAIL fill_count got %0d want %0d", count, DEPTH + 2); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_full_ready got %b want 0", in_ready); end
    n_vec++; if (next_val != DEPTH + 2) begin n_err++; $display("FAIL fill_accepted got %0d want %0d", next_val, DEPTH + 2); end
    tick();
    out_ready = 1'b1;
    exp_val = 0;
    cyc = 0;
    while (exp_val < DEPTH + 2 && cyc < 200) begin
      @(negedge clk);
      if (out_valid) begin
        n_vec++; if (out_data !== DW'(exp_val)) begin n_err++; $display("FAIL fill_drain got %h want %h", out_data, DW'(exp_val)); end
        exp_val++;
      end
      tick();
      cyc++;
    end
    n_vec++; if (exp_val != DEPTH + 2) begin n_err++; $display("FAIL fill_drain_timeout got %0d words want %0d", exp_val, DEPTH + 2); end
    @(negedge clk);
    n_vec++; if (count !== '0) begin n_err++; $display("FAIL fill_empty_count got %0d want 0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_stream();
    int sent;
    int got;
    bit started;
    apply_reset(2);
    sent = 0; got = 0; started = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 130 && got < 100; c++) begin
      in_valid = (sent < 100);
      in_data  = DW'(16'h0100 + sent);
      @(negedge clk);
      if (in_valid) begin
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready cyc %0d got %b want 1", c, in_ready); end
        if (in_ready) sent++;
      end
      if (out_valid) begin
        if (!started) begin
          started = 1'b1;
          n_vec++; if (c != 3) begin n_err++; $display("FAIL stream_latency got cyc %0d want 3", c); end
        end
        n_vec++; if (out_data !== DW'(16'h0100 + got)) begin
          n_err++; $display("FAIL stream_data got %h want %h", out_data, DW'(16'h0100 + got));
        end
        got++;
      end else if (started) begin
        n_vec++; n_err++; $display("FAIL stream_gap at word %0d got out_valid=0 want 1", got);
      end
      tick();
    end
    in_valid = 1'b0;
    n_vec++; if (got != 100) begin n_err++; $display("FAIL stream_total got %0d want 100", got); end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [DW-1:0] q[$];
    int stall;
    int rdy_pct;
    apply_reset(2);
    stall = 0;
    for (int c = 0; c < 1000; c++) begin
      rdy_pct   = (c < 500) ? 30 : 75;
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      in_data   = DW'($urandom);
      @(negedge clk);
      n_vec++; if (count !== 7'(q.size())) begin n_err++; $display("FAIL rand_count cyc %0d got %0d want %0d", c, count, q.size()); end
      n_vec++; if (write_enable !== (in_valid && in_ready)) begin
        n_err++; $display("FAIL rand_we cyc %0d got %b want %b", c, write_enable, in_valid && in_ready);
      end
      if (q.size() < DEPTH) begin
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rand_ready cyc %0d got %b want 1", c, in_ready); end
      end else if (q.size() >= DEPTH + 2) begin
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rand_full cyc %0d got %b want 0", c, in_ready); end
      end
      if (q.size() == 0) begin
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rand_empty_valid cyc %0d got %b want 0", c, out_valid); end
        stall = 0;
      end else if (!out_valid) begin
        stall++;
        n_vec++; if (stall > 2) begin n_err++; $display("FAIL rand_stall cyc %0d got %0d idle cycles want <=2", c, stall); end
      end else begin
        stall = 0;
      end
      if (out_valid && q.size() > 0) begin
        n_vec++; if (out_data !== q[0]) begin n_err++; $display("FAIL rand_data cyc %0d got %h want %h", c, out_data, q[0]); end
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && in_ready) q.push_back(in_data);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    int cyc;
    apply_reset(2);
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = DW'(16'h0B00 + i);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (count !== 7'd10) begin n_err++; $display("FAIL midrst_pre_count got %0d want 10", count); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (count !== '0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL midrst_cleared got count=%0d ov=%b want 0 0", count, out_valid);
    end
    in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (!out_valid && cyc < 10) begin
      tick();
      @(negedge clk);
      cyc++;
    end
    n_vec++; if (out_valid !== 1'b1 || out_data !== 16'h1234) begin
      n_err++; $display("FAIL midrst_first_word got ov=%b d=%h want 1 1234", out_valid, out_data);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
